// File: rtl/mul_pkg.sv
// Shared constants for the shared-multiplier controller: state encoding,
// default hold time and requester ids.
package mul_pkg;

  // Controller states (kept as plain 2-bit constants for older tools)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default number of cycles the operands are held before capture
  localparam int MUL_LATENCY = 4;

  // Requester ids
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/mul_32bit.sv
// Combinational signed multiplier producing the full double-width product.
// It is driven from registered operands and sampled several cycles later,
// so its delay is a timed multicycle path.
module mul_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product
);

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;

  // Sign-extend both operands to the product width so the low 2*WIDTH bits
  // of the multiply are the exact two's-complement result.
  assign a_ext   = signed'({{WIDTH{multiplicand[WIDTH-1]}}, multiplicand});
  assign b_ext   = signed'({{WIDTH{multiplier[WIDTH-1]}}, multiplier});
  assign product = a_ext * b_ext;

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one signed multiplier between two requesters. Round-robin
// arbitration in IDLE, operands held for LATENCY cycles in CALC, product
// captured into hi/lo and announced with a one-cycle done pulse in DONE.
module mul_share_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = MUL_LATENCY
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             flush,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  logic [1:0]         state_reg, state_next;
  logic [WIDTH-1:0]   op_a_reg, op_a_next;
  logic [WIDTH-1:0]   op_b_reg, op_b_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               rr_reg, rr_next;
  logic               owner_reg, owner_next;
  logic [1:0]         gnt_reg, gnt_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               done_id_reg, done_id_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               winner;
  logic [2*WIDTH-1:0] product;

  mul_32bit #(
    .WIDTH(WIDTH)
  ) u_mul (
    .multiplicand(op_a_reg),
    .multiplier  (op_b_reg),
    .product     (product)
  );

  // Next-state logic: arbitration, hold counter, capture and flush handling
  always_comb begin
    state_next   = state_reg;
    op_a_next    = op_a_reg;
    op_b_next    = op_b_reg;
    cnt_next     = cnt_reg;
    rr_next      = rr_reg;
    owner_next   = owner_reg;
    gnt_next     = 2'b00;
    done_next    = 1'b0;
    done_id_next = done_id_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    winner       = REQ_CPU;

    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          // A lone requester always wins; a tie goes to the favoured one
          if (req == 2'b11) begin
            winner = rr_reg;
          end else if (req[REQ_AUX]) begin
            winner = REQ_AUX;
          end else begin
            winner = REQ_CPU;
          end
          op_a_next        = (winner == REQ_AUX) ? a1 : a0;
          op_b_next        = (winner == REQ_AUX) ? b1 : b0;
          gnt_next[winner] = 1'b1;
          owner_next       = winner;
          rr_next          = ~winner;
          cnt_next         = CNT_INIT;
          state_next       = ST_CALC;
        end
      end
      ST_CALC: begin
        // Flush beats a capture that would happen in the same cycle
        if (flush) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == '0) begin
          hi_next      = product[2*WIDTH-1:WIDTH];
          lo_next      = product[WIDTH-1:0];
          done_id_next = owner_reg;
          done_next    = 1'b1;
          state_next   = ST_DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next == ST_CALC) || (state_next == ST_DONE);
  end

  // State and output registers, cleared asynchronously by clr
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg   <= ST_IDLE;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      cnt_reg     <= '0;
      rr_reg      <= REQ_CPU;
      owner_reg   <= REQ_CPU;
      gnt_reg     <= 2'b00;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      done_id_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      op_a_reg    <= op_a_next;
      op_b_reg    <= op_b_next;
      cnt_reg     <= cnt_next;
      rr_reg      <= rr_next;
      owner_reg   <= owner_next;
      gnt_reg     <= gnt_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      done_id_reg <= done_id_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  assign gnt     = gnt_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign done_id = done_id_reg;
  assign hi      = hi_reg;
  assign lo      = lo_reg;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: a transaction-level model predicts every output
// each cycle, and directed sequences pin literal products, latency,
// arbitration order, flush and asynchronous clear.
module tb_mul_share_ctrl;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 4;

  logic        clk   = 1'b0;
  logic        clr   = 1'b1;
  logic [1:0]  req   = 2'b00;
  logic [31:0] a0    = '0;
  logic [31:0] b0    = '0;
  logic [31:0] a1    = '0;
  logic [31:0] b1    = '0;
  logic        flush = 1'b0;
  logic [1:0]  gnt;
  logic        busy;
  logic        done;
  logic        done_id;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mul_share_ctrl #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .req    (req),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .flush  (flush),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .done_id(done_id),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Cycle counter, stepped at each rising edge
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural model: counts edges since acceptance (m_k, -1 = free)
  int                 m_k   = -1;
  logic               m_rr  = 1'b0;
  logic               m_owner = 1'b0;
  logic               m_win;
  logic signed [63:0] m_prod = '0;
  logic signed [63:0] m_sa, m_sb;
  logic [1:0]         e_gnt = 2'b00;
  logic               e_busy = 1'b0;
  logic               e_done = 1'b0;
  logic               e_done_id = 1'b0;
  logic [31:0]        e_hi = '0;
  logic [31:0]        e_lo = '0;

  initial forever begin
    @(posedge clk or posedge clr);
    if (clr) begin
      m_k = -1; m_rr = 1'b0; m_owner = 1'b0;
      e_gnt = 2'b00; e_busy = 1'b0; e_done = 1'b0;
      e_done_id = 1'b0; e_hi = '0; e_lo = '0;
    end else begin
      e_gnt  = 2'b00;
      e_done = 1'b0;
      if (m_k < 0) begin
        if (req != 2'b00) begin
          m_win   = (req == 2'b11) ? m_rr : req[1];
          m_sa    = m_win ? $signed(a1) : $signed(a0);
          m_sb    = m_win ? $signed(b1) : $signed(b0);
          m_prod  = m_sa * m_sb;
          m_owner = m_win;
          m_rr    = ~m_win;
          e_gnt   = m_win ? 2'b10 : 2'b01;
          e_busy  = 1'b1;
          m_k     = 0;
        end else begin
          e_busy = 1'b0;
        end
      end else begin
        m_k++;
        if (m_k <= LATENCY && flush) begin
          m_k = -1; e_busy = 1'b0;
        end else if (m_k == LATENCY) begin
          {e_hi, e_lo} = m_prod;
          e_done_id = m_owner;
          e_done    = 1'b1;
          e_busy    = 1'b1;
        end else if (m_k > LATENCY) begin
          m_k = -1; e_busy = 1'b0;
        end else begin
          e_busy = 1'b1;
        end
      end
    end
  end

  // Compare process: every falling edge, DUT against model plus invariants
  initial forever begin
    @(negedge clk);
    chk("gnt", gnt, e_gnt);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("done_id", done_id, e_done_id);
    chk("hi", hi, e_hi);
    chk("lo", lo, e_lo);
    chk("gnt_onehot", ($countones(gnt) <= 1), 1);
    chk("gnt_done_excl", ((gnt != 2'b00) && done), 0);
  end

  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (gnt != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: got no gnt, required one within 20 cycles");
    end
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done, required one within 20 cycles");
    end
  endtask

  task automatic run_one(input string nm, input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    logic ok;
    int   g;
    @(posedge clk); #1;
    if (id) begin a1 = a; b1 = b; req = 2'b10; end
    else    begin a0 = a; b0 = b; req = 2'b01; end
    wait_gnt(ok);
    chk({nm, "_gnt"}, gnt, id ? 2'b10 : 2'b01);
    req = 2'b00;
    g   = cyc;
    wait_done(ok);
    if (ok) begin
      chk({nm, "_latency"}, cyc - g, LATENCY);
      chk({nm, "_hi"}, hi, ehi);
      chk({nm, "_lo"}, lo, elo);
      chk({nm, "_done_id"}, done_id, id);
    end
    $display("TXN %s id=%0d a=%h b=%h -> hi=%h lo=%h done_id=%0d", nm, id, a, b, hi, lo, done_id);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #3;
    clr = 1'b1;
    #1;
    chk("clr_async_gnt", gnt, 0);
    chk("clr_async_busy", busy, 0);
    chk("clr_async_done", done, 0);
    chk("clr_async_done_id", done_id, 0);
    chk("clr_async_hi", hi, 0);
    chk("clr_async_lo", lo, 0);
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    logic       ok;
    int         ng, nd;
    logic [1:0] gseq [3];
    logic       dseq [3];
    int         dcy  [3];

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    clr = 1'b0;

    // Single transactions and boundary products
    run_one("r0_16x10", 1'b0, 32'd16, 32'd10, 32'h0, 32'd160);
    run_one("r1_m3x7", 1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_one("min_x_min", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    run_one("max_x_min", 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);

    // Both requesters held high from reset for three transactions
    pulse_clr();
    a0 = 32'd2; b0 = 32'd3; a1 = 32'hFFFFFFFC; b1 = 32'd5;
    req = 2'b11;
    ng = 0; nd = 0;
    for (int t = 0; t < 40 && nd < 3; t++) begin
      @(posedge clk); #1;
      if (gnt != 2'b00 && ng < 3) begin
        gseq[ng] = gnt;
        ng++;
        if (ng == 3) req = 2'b00;
      end
      if (done) begin
        dseq[nd] = done_id;
        dcy[nd]  = cyc;
        nd++;
        $display("TXN arb done_id=%0d hi=%h lo=%h cycle=%0d", done_id, hi, lo, cyc);
      end
    end
    chk("arb_ngnt", ng, 3);
    chk("arb_ndone", nd, 3);
    if (ng == 3) begin
      chk("arb_gnt0", gseq[0], 2'b01);
      chk("arb_gnt1", gseq[1], 2'b10);
      chk("arb_gnt2", gseq[2], 2'b01);
    end
    if (nd == 3) begin
      chk("arb_id0", dseq[0], 0);
      chk("arb_id1", dseq[1], 1);
      chk("arb_id2", dseq[2], 0);
      chk("arb_space01", dcy[1] - dcy[0], LATENCY + 2);
      chk("arb_space12", dcy[2] - dcy[1], LATENCY + 2);
    end

    // Flush in the second CALC cycle of 5*5 after a 16*10
    run_one("pre_flush", 1'b0, 32'd16, 32'd10, 32'h0, 32'd160);
    @(posedge clk); #1;
    a0 = 32'd5; b0 = 32'd5; req = 2'b01;
    wait_gnt(ok);
    req = 2'b00;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_drop", busy, 0);
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      chk("flush_no_done", done, 0);
    end
    chk("flush_hi_kept", hi, 32'h0);
    chk("flush_lo_kept", lo, 32'd160);
    $display("TXN flush 5x5 aborted hi=%h lo=%h", hi, lo);
    run_one("post_flush", 1'b1, 32'd3, 32'd4, 32'h0, 32'd12);

    // Asynchronous clear in the middle of CALC
    run_one("pre_clr", 1'b0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
    @(posedge clk); #1;
    a0 = 32'd9; b0 = 32'd9; req = 2'b01;
    wait_gnt(ok);
    req = 2'b00;
    @(posedge clk);
    pulse_clr();
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      chk("clr_no_done", done, 0);
    end
    $display("TXN clr mid-calc hi=%h lo=%h busy=%0d", hi, lo, busy);
    a0 = 32'd6; b0 = 32'd7; a1 = 32'd8; b1 = 32'd9;
    req = 2'b11;
    wait_gnt(ok);
    chk("clr_rr_reset_gnt", gnt, 2'b01);
    req = 2'b00;
    wait_done(ok);
    if (ok) begin
      chk("clr_next_lo", lo, 32'd42);
      chk("clr_next_id", done_id, 0);
    end
    $display("TXN after clr both req -> done_id=%0d lo=%h", done_id, lo);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
